// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory-access stage (master) and the data memory (slave).
interface mem_access_unit_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    logic              bus_request;
    logic              bus_write_enable;
    logic [DATA_W-1:0] bus_address;
    logic [SEL_W-1:0]  bus_byte_select;
    logic [DATA_W-1:0] bus_write_data;
    logic [DATA_W-1:0] bus_read_data;
    logic              bus_acknowledge;

    modport master (
        output bus_request,
        output bus_write_enable,
        output bus_address,
        output bus_byte_select,
        output bus_write_data,
        input  bus_read_data,
        input  bus_acknowledge
    );

    modport slave (
        input  bus_request,
        input  bus_write_enable,
        input  bus_address,
        input  bus_byte_select,
        input  bus_write_data,
        output bus_read_data,
        output bus_acknowledge
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage of the pipelined MIPS core; also acts as the MEM/WB latch.
// Runs loads/stores over a request/acknowledge data bus and stalls upstream until done.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned half/word accesses raise
// address_error instead of going to the bus).
module mem_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_register_write_enable,
    input  logic [4:0]  mem_register_write_address,
    input  logic [31:0] mem_register_write_data,
    input  logic [3:0]  mem_operation,
    input  logic [31:0] mem_store_data,
    mem_access_unit_if.master bus,
    output logic        stall_request,
    output logic        address_error,
    output logic        wb_register_write_enable,
    output logic [4:0]  wb_register_write_address,
    output logic [31:0] wb_register_write_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SEL_W  = 4;

    localparam logic [OP_W-1:0] OP_NONE = 4'd0;
    localparam logic [OP_W-1:0] OP_LB   = 4'd1;
    localparam logic [OP_W-1:0] OP_LBU  = 4'd2;
    localparam logic [OP_W-1:0] OP_LH   = 4'd3;
    localparam logic [OP_W-1:0] OP_LHU  = 4'd4;
    localparam logic [OP_W-1:0] OP_LW   = 4'd5;
    localparam logic [OP_W-1:0] OP_SB   = 4'd6;
    localparam logic [OP_W-1:0] OP_SH   = 4'd7;
    localparam logic [OP_W-1:0] OP_SW   = 4'd8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ACK = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              bwe_q, bwe_d;
    logic [DATA_W-1:0] baddr_q, baddr_d;
    logic [SEL_W-1:0]  bsel_q, bsel_d;
    logic [DATA_W-1:0] bwdata_q, bwdata_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic              aerr_q, aerr_d;
    logic              wbwe_q, wbwe_d;
    logic [REG_AW-1:0] wbaddr_q, wbaddr_d;
    logic [DATA_W-1:0] wbdata_q, wbdata_d;

    logic              is_load;
    logic              is_store;
    logic [1:0]        size;
    logic [1:0]        lane;
    logic              misaligned;
    logic [SEL_W-1:0]  sel_c;
    logic [DATA_W-1:0] wdata_c;

    assign lane = mem_register_write_data[1:0];

    // Select and extend the addressed lane(s) of a load response.
    function automatic logic [DATA_W-1:0] extract_load(
        input logic [OP_W-1:0]   op,
        input logic [1:0]        ln,
        input logic [DATA_W-1:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (ln)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = ln[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   extract_load = {{24{b[7]}}, b};
            OP_LBU:  extract_load = {24'h000000, b};
            OP_LH:   extract_load = {{16{h[15]}}, h};
            OP_LHU:  extract_load = {16'h0000, h};
            default: extract_load = rdata;
        endcase
    endfunction

    // Decode operation class and access size; 9-15 fall into NONE.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SZ_WORD;
        case (mem_operation)
            OP_LB, OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
            OP_LW:         begin is_load  = 1'b1; size = SZ_WORD; end
            OP_SB:         begin is_store = 1'b1; size = SZ_BYTE; end
            OP_SH:         begin is_store = 1'b1; size = SZ_HALF; end
            OP_SW:         begin is_store = 1'b1; size = SZ_WORD; end
            default:       begin is_load  = 1'b0; is_store = 1'b0; end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
    assign misaligned = (is_load || is_store) &&
                        (((size == SZ_HALF) && lane[0]) ||
                         ((size == SZ_WORD) && (lane != 2'b00)));
`else
    // Low address bits below the access size are simply ignored.
    assign misaligned = 1'b0;
`endif

    // Little-endian lane enables and replicated store data.
    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = mem_store_data;
        case (size)
            SZ_BYTE: begin
                sel_c   = SEL_W'(4'b0001 << lane);
                wdata_c = {4{mem_store_data[7:0]}};
            end
            SZ_HALF: begin
                sel_c   = lane[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{mem_store_data[15:0]}};
            end
            default: begin
                sel_c   = 4'b1111;
                wdata_c = mem_store_data;
            end
        endcase
    end

    // Next-state, next-output and stall logic.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        bwe_d         = bwe_q;
        baddr_d       = baddr_q;
        bsel_d        = bsel_q;
        bwdata_d      = bwdata_q;
        op_d          = op_q;
        lane_d        = lane_q;
        aerr_d        = 1'b0;
        wbwe_d        = wbwe_q;
        wbaddr_d      = wbaddr_q;
        wbdata_d      = wbdata_q;
        stall_request = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_load || is_store) begin
                    if (misaligned) begin
                        aerr_d = 1'b1;
                        wbwe_d = 1'b0;
                    end else begin
                        stall_request = 1'b1;
                        state_d       = ST_WAIT_ACK;
                        req_d         = 1'b1;
                        bwe_d         = is_store;
                        baddr_d       = {mem_register_write_data[31:2], 2'b00};
                        bsel_d        = sel_c;
                        bwdata_d      = wdata_c;
                        op_d          = mem_operation;
                        lane_d        = lane;
                        wbwe_d        = 1'b0;
                    end
                end else begin
                    wbwe_d   = mem_register_write_enable;
                    wbaddr_d = mem_register_write_address;
                    wbdata_d = mem_register_write_data;
                end
            end
            ST_WAIT_ACK: begin
                wbwe_d = 1'b0;
                if (bus.bus_acknowledge) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    if ((op_q >= OP_LB) && (op_q <= OP_LW)) begin
                        wbwe_d   = 1'b1;
                        wbaddr_d = mem_register_write_address;
                        wbdata_d = extract_load(op_q, lane_q, bus.bus_read_data);
                    end
                end else begin
                    stall_request = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            bwe_q    <= 1'b0;
            baddr_q  <= '0;
            bsel_q   <= '0;
            bwdata_q <= '0;
            op_q     <= OP_NONE;
            lane_q   <= 2'b00;
            aerr_q   <= 1'b0;
            wbwe_q   <= 1'b0;
            wbaddr_q <= '0;
            wbdata_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            bwe_q    <= bwe_d;
            baddr_q  <= baddr_d;
            bsel_q   <= bsel_d;
            bwdata_q <= bwdata_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            aerr_q   <= aerr_d;
            wbwe_q   <= wbwe_d;
            wbaddr_q <= wbaddr_d;
            wbdata_q <= wbdata_d;
        end
    end

    assign bus.bus_request          = req_q;
    assign bus.bus_write_enable     = bwe_q;
    assign bus.bus_address          = baddr_q;
    assign bus.bus_byte_select      = bsel_q;
    assign bus.bus_write_data       = bwdata_q;
    assign address_error            = aerr_q;
    assign wb_register_write_enable = wbwe_q;
    assign wb_register_write_address = wbaddr_q;
    assign wb_register_write_data   = wbdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit; bus slave is driven inline by the sequence.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        mem_register_write_enable;
    logic [4:0]  mem_register_write_address;
    logic [31:0] mem_register_write_data;
    logic [3:0]  mem_operation;
    logic [31:0] mem_store_data;
    logic        stall_request;
    logic        address_error;
    logic        wb_register_write_enable;
    logic [4:0]  wb_register_write_address;
    logic [31:0] wb_register_write_data;

    mem_access_unit_if bus_if ();

    mem_access_unit dut (
        .clock                      (clock),
        .reset                      (reset),
        .mem_register_write_enable  (mem_register_write_enable),
        .mem_register_write_address (mem_register_write_address),
        .mem_register_write_data    (mem_register_write_data),
        .mem_operation              (mem_operation),
        .mem_store_data             (mem_store_data),
        .bus                        (bus_if),
        .stall_request              (stall_request),
        .address_error              (address_error),
        .wb_register_write_enable   (wb_register_write_enable),
        .wb_register_write_address  (wb_register_write_address),
        .wb_register_write_data     (wb_register_write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        full;
    } wb_exp_t;

    bus_exp_t bus_q[$];
    wb_exp_t  wb_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bus_exp_t model_bus(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] sd);
        bus_exp_t e;
        e.we   = (op >= 4'd6) && (op <= 4'd8);
        e.addr = a & 32'hFFFF_FFFC;
        case (op)
            4'd1, 4'd2, 4'd6: begin
                e.sel = 4'(1 << a[1:0]);
                e.wdata = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            end
            4'd3, 4'd4, 4'd7: begin
                e.sel = a[1] ? 4'hC : 4'h3;
                e.wdata = {sd[15:0], sd[15:0]};
            end
            default: begin
                e.sel = 4'hF;
                e.wdata = sd;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] bs;
        logic [31:0] hs;
        bs = rd >> (32'(a[1:0]) * 8);
        hs = rd >> (a[1] ? 16 : 0);
        case (op)
            4'd1:    return {{24{bs[7]}}, bs[7:0]};
            4'd2:    return {24'h0, bs[7:0]};
            4'd3:    return {{16{hs[15]}}, hs[15:0]};
            4'd4:    return {16'h0, hs[15:0]};
            default: return rd;
        endcase
    endfunction

    // Drives one EX/MEM operation at a negedge, plays the bus slave, then checks MEM/WB.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] dest, input logic en,
                         input int waits, input logic [31:0] rd);
        bus_exp_t be;
        wb_exp_t  we;
        int       stalls;
        int       left;
        bit       done;
        bit       mem;
        mem = (op >= 4'd1) && (op <= 4'd8);
        if (mem) bus_q.push_back(model_bus(op, a, sd));
        if (op >= 4'd1 && op <= 4'd5)
            we = '{we: 1'b1, addr: dest, data: model_load(op, a, rd), full: 1'b1};
        else if (mem)
            we = '{we: 1'b0, addr: dest, data: 32'h0, full: 1'b0};
        else
            we = '{we: en, addr: dest, data: a, full: 1'b1};
        wb_q.push_back(we);

        mem_operation              = op;
        mem_register_write_data    = a;
        mem_store_data             = sd;
        mem_register_write_address = dest;
        mem_register_write_enable  = en;
        stalls = 0;
        left   = waits;
        done   = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (!stall_request) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clock);
            if (bus_q.size() > 0) begin
                be = bus_q[0];
                check({tag, ".req"}, 32'(bus_if.bus_request), 32'd1);
                check({tag, ".addr"}, bus_if.bus_address, be.addr);
                check({tag, ".sel"}, 32'(bus_if.bus_byte_select), 32'(be.sel));
                check({tag, ".bwe"}, 32'(bus_if.bus_write_enable), 32'(be.we));
                if (be.we) check({tag, ".wdata"}, bus_if.bus_write_data, be.wdata);
            end
            if (left == 0) begin
                bus_if.bus_acknowledge = 1'b1;
                bus_if.bus_read_data   = rd;
            end else begin
                left--;
            end
        end
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL %s.timeout observed=stuck expected=ack", tag);
        end
        check({tag, ".stalls"}, 32'(stalls), mem ? 32'(waits + 1) : 32'd0);
        @(negedge clock);
        bus_if.bus_acknowledge     = 1'b0;
        bus_if.bus_read_data       = 32'hDEAD_BEEF;
        mem_operation              = 4'd0;
        mem_register_write_enable  = 1'b0;
        if (mem) void'(bus_q.pop_front());
        we = wb_q.pop_front();
        check({tag, ".wb_we"}, 32'(wb_register_write_enable), 32'(we.we));
        if (we.full) begin
            check({tag, ".wb_addr"}, 32'(wb_register_write_address), 32'(we.addr));
            check({tag, ".wb_data"}, wb_register_write_data, we.data);
        end
        check({tag, ".req_drop"}, 32'(bus_if.bus_request), 32'd0);
    endtask

    initial begin
        reset                      = 1'b0;
        mem_operation              = 4'd0;
        mem_register_write_enable  = 1'b0;
        mem_register_write_address = 5'd0;
        mem_register_write_data    = 32'h0;
        mem_store_data             = 32'h0;
        bus_if.bus_acknowledge     = 1'b0;
        bus_if.bus_read_data       = 32'h0;

        #1;
        check("rst.req",     32'(bus_if.bus_request), 32'd0);
        check("rst.bwe",     32'(bus_if.bus_write_enable), 32'd0);
        check("rst.addr",    bus_if.bus_address, 32'd0);
        check("rst.sel",     32'(bus_if.bus_byte_select), 32'd0);
        check("rst.wdata",   bus_if.bus_write_data, 32'd0);
        check("rst.stall",   32'(stall_request), 32'd0);
        check("rst.aerr",    32'(address_error), 32'd0);
        check("rst.wb_we",   32'(wb_register_write_enable), 32'd0);
        check("rst.wb_addr", 32'(wb_register_write_address), 32'd0);
        check("rst.wb_data", wb_register_write_data, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        do_op("none", 4'd0, 32'h1234_5678, 32'h0, 5'd9, 1'b1, 0, 32'h0);
        do_op("lb",   4'd1, 32'h0000_0103, 32'h0, 5'd3, 1'b0, 3, 32'h80AA_BBCC);
        do_op("sh",   4'd7, 32'h0000_0012, 32'h0000_BEEF, 5'd4, 1'b1, 0, 32'h0);
        do_op("sb",   4'd6, 32'h0000_0001, 32'h0000_00A5, 5'd5, 1'b0, 1, 32'h0);
        do_op("lw",   4'd5, 32'h0000_0040, 32'h0, 5'd6, 1'b0, 0, 32'h1122_3344);
        do_op("lhu",  4'd4, 32'h0000_0046, 32'h0, 5'd7, 1'b0, 0, 32'h1122_3344);
        do_op("lh",   4'd3, 32'h0000_0042, 32'h0, 5'd8, 1'b0, 2, 32'h8001_0000);
        do_op("op15", 4'd15, 32'h0000_00F0, 32'h0, 5'd10, 1'b1, 0, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        mem_operation              = 4'd5;
        mem_register_write_data    = 32'h0000_0002;
        mem_register_write_address = 5'd11;
        #1;
        check("mis.stall", 32'(stall_request), 32'd0);
        @(negedge clock);
        mem_operation = 4'd0;
        check("mis.aerr",  32'(address_error), 32'd1);
        check("mis.req",   32'(bus_if.bus_request), 32'd0);
        check("mis.wb_we", 32'(wb_register_write_enable), 32'd0);
        @(negedge clock);
        check("mis.aerr_pulse", 32'(address_error), 32'd0);
`else
        do_op("lw_mis", 4'd5, 32'h0000_0002, 32'h0, 5'd11, 1'b0, 0, 32'hCAFE_F00D);
        check("lw_mis.aerr", 32'(address_error), 32'd0);
`endif

        mem_operation              = 4'd5;
        mem_register_write_data    = 32'h0000_0080;
        mem_register_write_address = 5'd12;
        @(negedge clock);
        check("mrst.req_before", 32'(bus_if.bus_request), 32'd1);
        mem_operation = 4'd0;
        reset = 1'b0;
        #1;
        check("mrst.req",     32'(bus_if.bus_request), 32'd0);
        check("mrst.stall",   32'(stall_request), 32'd0);
        check("mrst.wb_we",   32'(wb_register_write_enable), 32'd0);
        check("mrst.wb_data", wb_register_write_data, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mrst.idle_req", 32'(bus_if.bus_request), 32'd0);
        do_op("post", 4'd0, 32'h0BAD_CAFE, 32'h0, 5'd13, 1'b1, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Memory-access stage of the pipelined MIPS core; the consuming end of the EX/MEM pipeline register.
- Takes the EX/MEM register-write triple plus memory-operation fields, runs loads/stores on the data bus with a request/acknowledge handshake, and stalls upstream until each access completes.
- Drives the registered MEM/WB register-write triple, so it also acts as the MEM/WB latch.

## Interface
Parameters: none.

Ports (name, direction, width, meaning). One clock; `reset` is asynchronous and active-low.
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- mem_register_write_enable  in  1  EX/MEM write enable
- mem_register_write_address  in  5  EX/MEM destination register
- mem_register_write_data  in  32  ALU result; memory address for loads/stores
- mem_operation  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as NONE
- mem_store_data  in  32  store source register value
- bus_request  out  1  registered, transaction in progress
- bus_write_enable  out  1  registered, 1 = store
- bus_address  out  32  registered, word-aligned ({addr[31:2],2'b00})
- bus_byte_select  out  4  registered, lane enables (bit n = bits 8n+7:8n)
- bus_write_data  out  32  registered, lane-replicated store data
- bus_read_data  in  32  valid when bus_acknowledge=1
- bus_acknowledge  in  1  completes the transaction this cycle
- stall_request  out  1  combinational; upstream holds EX/MEM inputs while 1
- address_error  out  1  registered one-cycle pulse (see Configuration)
- wb_register_write_enable  out  1  MEM/WB write enable
- wb_register_write_address  out  5  MEM/WB destination
- wb_register_write_data  out  32  MEM/WB data

## Operation
- States: IDLE, WAIT_ACK.
- IDLE, op NONE: next edge copies the EX/MEM triple to the wb_* outputs; no stall.
- IDLE, load/store op: stall_request=1. Next edge:
  - latch bus_* fields, bus_request←1, go to WAIT_ACK
  - wb_register_write_enable←0 (bubble)
- WAIT_ACK, bus_acknowledge=0: stall_request=1, bus outputs hold, wb_* hold with enable 0.
- WAIT_ACK, bus_acknowledge=1: stall_request=0. Next edge:
  - bus_request←0, go to IDLE
  - load: wb enable←1, address←input address, data←extracted read data
  - store: wb enable←0
- bus_acknowledge is ignored in IDLE.
- Little-endian lanes, lane = addr[1:0]:
  - byte: select 1<<addr[1:0], write data {4{b[7:0]}}
  - half: select addr[1] ? 4'b1100 : 4'b0011, write data {2{b[15:0]}}
  - word: select 4'b1111, write data unchanged
- Load extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- Loads write the register regardless of mem_register_write_enable; stores never write.

## Timing
- Reset values: all outputs 0, state IDLE. This includes bus_*, wb_*, address_error; stall_request is 0 because state is IDLE and (per upstream) mem_operation is NONE during reset.
- Reset asserted mid-transaction: immediate return to IDLE, bus_request drops asynchronously, the access is abandoned.
- Non-memory op: 1-cycle latency to wb_*.
- Memory op with zero-wait bus (ack in first WAIT_ACK cycle): 2 cycles, with stall_request high for exactly 1 cycle.
- Each wait cycle adds 1 cycle.
- bus_request stays high continuously from issue to the acknowledge edge. Bus fields are stable throughout.
- Back-to-back memory ops: next op is seen in IDLE on the cycle after the acknowledge edge. Minimum 2 cycles per access, no overlap.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0
  - a misaligned op in IDLE issues no bus transaction and raises no stall
  - next edge: address_error←1 for one cycle, wb enable←0
- MEM_ALIGN_CHECK_EN undefined:
  - address_error tied 0
  - addr[0] is ignored for halfwords and addr[1:0] for words; the access proceeds as if aligned

## Test plan
- Reset during WAIT_ACK (bus_request=1) → bus_request, wb_*, stall_request all 0 immediately; state IDLE after release.
- op NONE, enable=1, address 5'd9, data 0x1234_5678 → next cycle wb_* = 1/9/0x1234_5678, stall never high.
- LB at addr 0x0000_0103, ack after 3 wait cycles, read data 0x80AA_BBCC:
  - bus_address 0x0000_0100, select 4'b1000
  - stall high for 4 cycles
  - wb data 0xFFFF_FF80
- SH at addr 0x0000_0012, store data 0x0000_BEEF, zero-wait:
  - select 4'b1100, write data 0xBEEF_BEEF, bus_write_enable 1
  - wb enable stays 0
- Back-to-back LW 0x40 then LHU 0x46, zero-wait, read data 0x1122_3344 for both:
  - wb data 0x1122_3344, then 0x0000_1122
  - each access 2 cycles
- With MEM_ALIGN_CHECK_EN, LW at 0x0000_0002:
  - address_error pulses 1 cycle, bus_request stays 0, stall 0
  - without the macro, bus_address is 0x0000_0000 and the load completes normally
